// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, word-array type, state encoding and round functions
package sha256_pkg;

    typedef logic [7:0][31:0] word8_t;

    typedef enum logic [1:0] {IDLE, COMPUTE, FINAL, HOLD} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round over working variables a..h
module sha256_round
    import sha256_pkg::*;
(
    input  word8_t      st_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output word8_t      st_o
);

    logic [31:0] t1, t2;

    // Word 0 is a, word 7 is h; the shift moves every variable one slot up
    always_comb begin
        t1   = st_i[7] + bsig1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
        t2   = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
        st_o = {st_i[6:4], st_i[3] + t1, st_i[2:0], t1 + t2};
    end

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression with configurable rounds per cycle
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int FINAL_ADD        = 1,
    parameter int TAG_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  word8_t           in_h,
    input  word8_t           in_state,
    input  logic [511:0]     in_block,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output word8_t           out_hash,
    output word8_t           out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
        $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t                 state_q, state_d;
    logic [5:0]             cnt_q;
    word8_t                 h_q, ws_q, hash_fin, out_hash_q, out_state_q;
    logic [15:0][31:0]      w_q;
    logic [15+R:0][31:0]    ext;
    logic [TAG_W-1:0]       tag_q, out_tag_q;
    word8_t                 chain [R+1];
    logic                   accept, last;

    assign in_ready  = state_q == IDLE;
    assign busy      = !in_ready;
    assign out_valid = state_q == HOLD;
    assign out_hash  = out_hash_q;
    assign out_state = out_state_q;
    assign out_tag   = out_tag_q;
    assign accept    = in_valid && in_ready;
    assign last      = cnt_q == 6'(64 - R);
    assign chain[0]  = ws_q;

    for (genvar k = 0; k < R; k++) begin : g_round
        sha256_round u_round (
            .st_i(chain[k]),
            .k_i (K[cnt_q + 6'(k)]),
            .w_i (ext[k]),
            .st_o(chain[k+1])
        );
    end

    // Extend the 16-word window by R schedule words; word j is W[t+j]
    always_comb begin
        ext[15:0] = w_q;
        for (int j = 16; j < 16 + R; j++)
            ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
    end

    // Final chaining value: feed-forward add or plain pass-through of in_h
    always_comb begin
        for (int i = 0; i < 8; i++)
            hash_fin[i] = FINAL_ADD != 0 ? h_q[i] + ws_q[i] : h_q[i];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? COMPUTE : IDLE;
            COMPUTE: state_d = last ? FINAL : COMPUTE;
            FINAL:   state_d = HOLD;
            HOLD:    state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Control state, round counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_hash_q  <= '0;
            out_state_q <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= accept ? 6'd0 : state_q == COMPUTE ? cnt_q + 6'(R) : cnt_q;
            if (state_q == FINAL) begin
                out_hash_q  <= hash_fin;
                out_state_q <= ws_q;
                out_tag_q   <= tag_q;
            end
        end
    end

    // Input capture on accept, then window slide and working-state update while computing
    always_ff @(posedge clk) begin
        if (accept) begin
            h_q   <= in_h;
            ws_q  <= in_state;
            w_q   <= in_block;
            tag_q <= in_tag;
        end else if (state_q == COMPUTE) begin
            ws_q <= chain[R];
            w_q  <= ext[15+R:R];
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: reference-model bench over five engine configurations sharing one stimulus
module tb_sha256_round_engine;
    import sha256_pkg::word8_t;

    localparam int N = 5;
    localparam int RPC [N] = '{1, 2, 4, 8, 1};
    localparam int FA  [N] = '{1, 1, 1, 1, 0};
    localparam int LAT [N] = '{66, 34, 18, 10, 66};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVW [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] ABCW [8] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    logic         clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    word8_t       in_h = '0, in_state = '0;
    logic [511:0] in_block = '0;
    logic [31:0]  in_tag = '0;
    logic [N-1:0] in_ready, out_valid, busy;
    word8_t       out_hash [N], out_state [N];
    logic [31:0]  out_tag [N];

    int     checks = 0, failures = 0, cyc = 0;
    bit     chk_en = 0;
    bit     m_idle [N] = '{default: 1'b1};
    int     m_age [N] = '{default: 0};
    word8_t e_hash [N], e_state [N];
    logic [31:0] e_tag [N];
    word8_t IV, ABC, ABC_M_IV;
    logic [511:0] ABC_BLK;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sha256_round_engine #(.ROUNDS_PER_CYCLE(RPC[g]), .FINAL_ADD(FA[g]), .TAG_W(32)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .in_h     (in_h),
            .in_state (in_state),
            .in_block (in_block),
            .in_tag   (in_tag),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_hash (out_hash[g]),
            .out_state(out_state[g]),
            .out_tag  (out_tag[g]),
            .busy     (busy[g])
        );
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward compression with a full 64-word schedule; returns a..h after round 63
    function automatic word8_t compress(input word8_t st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        word8_t r;
        for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = st[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic word8_t add8(input word8_t a, input word8_t b);
        word8_t r;
        for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
        return r;
    endfunction

    function automatic word8_t rnd8();
        word8_t r;
        for (int i = 0; i < 8; i++) r[i] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string nm, input int i, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    // Timeline model: each engine is busy for 64/R+1 edges after the accept edge, then holds its result
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_idle[i] = 1;
                m_age[i]  = 0;
            end else if (m_idle[i]) begin
                if (in_valid) begin
                    m_idle[i]  = 0;
                    m_age[i]   = 0;
                    e_state[i] = compress(in_state, in_block);
                    e_hash[i]  = FA[i] != 0 ? add8(in_h, e_state[i]) : in_h;
                    e_tag[i]   = in_tag;
                end
            end else if (m_age[i] >= 64 / RPC[i] + 1) begin
                if (out_ready) m_idle[i] = 1;
            end else begin
                m_age[i]++;
            end
        end
    end

    // Per-cycle comparison of every engine against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                bit mv;
                mv = !m_idle[i] && m_age[i] >= 64 / RPC[i] + 1;
                chk("in_ready", i, in_ready[i], m_idle[i]);
                chk("busy", i, busy[i], !m_idle[i]);
                chk("out_valid", i, out_valid[i], mv);
                if (mv) begin
                    chk("out_hash", i, out_hash[i], e_hash[i]);
                    chk("out_state", i, out_state[i], e_state[i]);
                    chk("out_tag", i, out_tag[i], e_tag[i]);
                end
            end
        end
    end

    task automatic check_cleared(input string nm);
        for (int i = 0; i < N; i++) begin
            chk({nm, "_valid"}, i, out_valid[i], 1'b0);
            chk({nm, "_busy"}, i, busy[i], 1'b0);
            chk({nm, "_ready"}, i, in_ready[i], 1'b1);
            chk({nm, "_hash"}, i, out_hash[i], '0);
            chk({nm, "_state"}, i, out_state[i], '0);
            chk({nm, "_tag"}, i, out_tag[i], '0);
        end
    endtask

    // Offer a block; if results are held, release them in the same cycle so the accept lands one cycle later
    task automatic start(input word8_t h, input word8_t st, input logic [511:0] blk, input logic [31:0] tag,
                         output int c);
        in_h = h; in_state = st; in_block = blk; in_tag = tag; in_valid = 1;
        if (!m_idle[0]) begin
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
        end
        c = cyc;
        @(negedge clk);
        in_valid = 0;
        in_h = rnd8(); in_state = rnd8(); in_block = rnd_blk(); in_tag = $urandom;
    endtask

    task automatic run(input word8_t h, input word8_t st, input logic [511:0] blk, input logic [31:0] tag,
                       input int extra);
        int c;
        int first [N];
        bit done;
        start(h, st, blk, tag, c);
        for (int i = 0; i < N; i++) first[i] = -1;
        for (int n = 0; n < 200; n++) begin
            if (n == 3) begin
                in_valid = 1; in_h = rnd8(); in_state = rnd8(); in_block = rnd_blk(); in_tag = $urandom;
            end
            if (n == 4) in_valid = 0;
            done = 1;
            for (int i = 0; i < N; i++) begin
                if (first[i] < 0 && out_valid[i]) first[i] = cyc - c;
                if (first[i] < 0) done = 0;
            end
            if (done) break;
            @(negedge clk);
        end
        in_valid = 0;
        for (int i = 0; i < N; i++) chk("latency", i, first[i], LAT[i]);
        repeat (extra) @(negedge clk);
    endtask

    task automatic check_abc();
        for (int i = 0; i < N - 1; i++) chk("abc_hash", i, out_hash[i], ABC);
        chk("nofa_hash", N - 1, out_hash[N-1], IV);
        chk("nofa_state", N - 1, out_state[N-1], ABC_M_IV);
        chk("nofa_tag", N - 1, out_tag[N-1], 32'hDEADBEEF);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 8; i++) begin
            IV[i]       = IVW[i];
            ABC[i]      = ABCW[i];
            ABC_M_IV[i] = ABCW[i] - IVW[i];
        end
        ABC_BLK          = '0;
        ABC_BLK[31:0]    = 32'h61626380;
        ABC_BLK[511:480] = 32'h00000018;
        chk("model_abc", 0, add8(IV, compress(IV, ABC_BLK)), ABC);

        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset  = 0;
        chk_en = 1;

        run(IV, IV, ABC_BLK, 32'hDEADBEEF, 0);
        check_abc();

        run(rnd8(), rnd8(), rnd_blk(), $urandom, 10);
        for (int k = 0; k < 5; k++) run(rnd8(), rnd8(), rnd_blk(), $urandom, k);
        run(IV, IV, ABC_BLK, 32'hDEADBEEF, 2);
        check_abc();

        start(IV, IV, ABC_BLK, 32'hDEADBEEF, c);
        repeat (29) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check_cleared("midrst");
        repeat (3) @(negedge clk);

        run(IV, IV, ABC_BLK, 32'hDEADBEEF, 1);
        check_abc();

        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
